apu_envelope_bank: RTL and testbench
====================================

// Module: apu_envelope_bank
// PURPOSE
//  Parametrised bank of NUM_CH APU envelope generators (pulse1, pulse2, noise by default).
//  Each channel is a reloadable period divider driving a decaying volume counter, with loop and
//  constant-volume modes. Clocked by the frame sequencer's quarter-frame pulse.
//  Feeds per-channel volume to the channel mixers.
// PARAMETERS
//  NUM_CH    3  number of independent envelope channels
//  VOL_W     4  width of decay level / volume output; decay max DMAX = 2**VOL_W-1
//  PERIOD_W  4  width of divider period / constant-volume value (PERIOD_W <= VOL_W)
// PORTS
//  clk            in   1                  system clock
//  rst            in   1                  synchronous, active-high reset
//  clk_en         in   1                  APU cycle enable; all state frozen and inputs ignored when 0
//  quarter_frame  in   1                  quarter-frame tick; acted on only when clk_en=1
//  wr_en          in   NUM_CH             per-channel config write strobe (one-hot or multiple)
//  wr_loop        in   1                  config: loop decay (also length-halt in the channel)
//  wr_const       in   1                  config: constant-volume mode
//  wr_period      in   PERIOD_W           config: divider period / constant volume value
//  start          in   NUM_CH             per-channel envelope restart (length-reg write)
//  volume         out  NUM_CH*VOL_W       channel i at [i*VOL_W +: VOL_W]
// BEHAVIOUR
//  - Sync reset: all cfg regs, dividers, decay levels, start flags = 0; volume = 0 next edge.
//  - Per-channel state: loop, cnst, period[PERIOD_W], div[PERIOD_W], decay[VOL_W], sflag.
//  - Config write (clk_en & wr_en[i]): loop/cnst/period <= wr_*; visible next cycle.
//  - Start (clk_en & start[i] & ~quarter_frame): sflag[i] <= 1.
//  - Quarter-frame step (clk_en & quarter_frame), per channel, priority order:
//    1. sflag | start[i]: decay <= DMAX; div <= period; sflag <= 0.
//    2. else div == 0: div <= period; decay <= (decay != 0) ? decay-1 : (loop ? DMAX : 0).
//    3. else div <= div-1.
//  - Start coincident with quarter_frame is taken immediately (case 1); sflag stays 0.
//  - Config write coincident with quarter_frame: step uses the OLD cfg values.
//  - Divider period P gives one decay step every P+1 quarter frames; P=0 steps every tick.
//  - Decay saturates at 0 when loop=0; with loop=1 wraps 0 -> DMAX on next divider expiry.
//  - volume[i] = cnst ? zero-extended period : decay; combinational from regs (0-cycle).
//  - Changing cnst does not disturb div/decay; the envelope keeps running underneath.
//  - Channels are fully independent; no shared state besides the wr_* data bus.
//  - Mid-operation rst overrides all strobes in the same cycle.
// CONFIGURATION
//  APU_ENV_MUTE_EN defined: adds input len_nz [NUM_CH]; volume[i] forced 0 when len_nz[i]=0
//    (length counter expired), internal envelope state unaffected.
//  APU_ENV_MUTE_EN undefined: no len_nz port; volume purely from the envelope as above.
// TESTING
//  1. rst=1 one cycle, clk_en=1 -> all volume=0; hold 10 qf ticks, no start -> volume stays 0.
//  2. ch0 cfg loop=0,cnst=0,period=2; start[0]; qf ticks every 4 clks -> 1st tick vol=15,
//     then decrements every 3 ticks to 0 and stays 0 (45+ ticks total).
//  3. ch1 loop=1,period=0, start -> vol 15,14,..,0,15,14 on consecutive qf ticks (wrap).
//  4. ch2 cnst=1,period=9 -> volume=9 immediately; switch cnst=0 -> shows running decay value.
//  5. start[0] and quarter_frame same cycle -> vol=15 next cycle, no extra restart on next tick;
//     wr_en with qf same cycle -> step uses old period (check div reload value).
//  6. clk_en=0 with qf/start/wr_en pulsed -> no state change; (MUTE_EN) len_nz[0]=0 -> vol0=0,
//     len_nz[0]=1 again -> decay value resumes unchanged.

Source files
------------

// File: rtl/apu_envelope_bank.sv
// Bank of NUM_CH APU envelope generators stepped by the quarter-frame tick.
// Optional APU_ENV_MUTE_EN adds len_nz[] to force a channel's volume to 0 while its length counter is expired.
module apu_envelope_ch #(
    parameter int VOL_W    = 4,
    parameter int PERIOD_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic                quarter_frame,
    input  logic                wr_en,
    input  logic                wr_loop,
    input  logic                wr_const,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic                start,
    output logic [VOL_W-1:0]    volume
);
    localparam logic [VOL_W-1:0] DMAX = '1;

    typedef struct packed {
        logic                loop;
        logic                cnst;
        logic [PERIOD_W-1:0] period;
    } env_cfg_t;

    env_cfg_t            cfg_q;
    logic [PERIOD_W-1:0] div_q;
    logic [VOL_W-1:0]    decay_q;
    logic                sflag_q;
    logic [VOL_W-1:0]    period_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q   <= '0;
            div_q   <= '0;
            decay_q <= '0;
            sflag_q <= 1'b0;
        end else if (clk_en) begin
            // the step below reads cfg_q, so a coincident write only lands afterwards
            if (wr_en)
                cfg_q <= '{loop: wr_loop, cnst: wr_const, period: wr_period};
            if (quarter_frame) begin
                if (sflag_q || start) begin
                    decay_q <= DMAX;
                    div_q   <= cfg_q.period;
                    sflag_q <= 1'b0;
                end else if (div_q == '0) begin
                    div_q <= cfg_q.period;
                    if (decay_q != '0)
                        decay_q <= decay_q - 1'b1;
                    else
                        decay_q <= cfg_q.loop ? DMAX : '0;
                end else begin
                    div_q <= div_q - 1'b1;
                end
            end else if (start) begin
                sflag_q <= 1'b1;
            end
        end
    end

    always_comb begin
        period_ext                 = '0;
        period_ext[PERIOD_W-1:0]   = cfg_q.period;
    end

    assign volume = cfg_q.cnst ? period_ext : decay_q;
endmodule

module apu_envelope_bank #(
    parameter int NUM_CH   = 3,
    parameter int VOL_W    = 4,
    parameter int PERIOD_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    quarter_frame,
    input  logic [NUM_CH-1:0]       wr_en,
    input  logic                    wr_loop,
    input  logic                    wr_const,
    input  logic [PERIOD_W-1:0]     wr_period,
    input  logic [NUM_CH-1:0]       start,
`ifdef APU_ENV_MUTE_EN
    input  logic [NUM_CH-1:0]       len_nz,
`endif
    output logic [NUM_CH*VOL_W-1:0] volume
);
    logic [NUM_CH-1:0][VOL_W-1:0] ch_vol;
    logic [NUM_CH-1:0][VOL_W-1:0] out_vol;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        apu_envelope_ch #(
            .VOL_W    (VOL_W),
            .PERIOD_W (PERIOD_W)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .clk_en        (clk_en),
            .quarter_frame (quarter_frame),
            .wr_en         (wr_en[i]),
            .wr_loop       (wr_loop),
            .wr_const      (wr_const),
            .wr_period     (wr_period),
            .start         (start[i]),
            .volume        (ch_vol[i])
        );
`ifdef APU_ENV_MUTE_EN
        // mute only masks the output; the envelope keeps running
        assign out_vol[i] = len_nz[i] ? ch_vol[i] : '0;
`else
        assign out_vol[i] = ch_vol[i];
`endif
    end

    assign volume = out_vol;
endmodule

// File: tb/tb_apu_envelope_bank.sv
// Randomized + directed bench for apu_envelope_bank against a per-channel behavioural model.
module tb_apu_envelope_bank;
    localparam int NUM_CH   = 3;
    localparam int VOL_W    = 4;
    localparam int PERIOD_W = 4;
    localparam int DMAX     = (1 << VOL_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    clk_en;
    logic                    quarter_frame;
    logic [NUM_CH-1:0]       wr_en;
    logic                    wr_loop;
    logic                    wr_const;
    logic [PERIOD_W-1:0]     wr_period;
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH-1:0]       len_nz;
    logic [NUM_CH*VOL_W-1:0] volume;

    int total = 0;
    int bad   = 0;

    int m_loop[NUM_CH], m_cnst[NUM_CH], m_per[NUM_CH];
    int m_div[NUM_CH], m_dec[NUM_CH], m_sf[NUM_CH];

    always #5 clk = ~clk;

    apu_envelope_bank #(.NUM_CH(NUM_CH), .VOL_W(VOL_W), .PERIOD_W(PERIOD_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .quarter_frame (quarter_frame),
        .wr_en         (wr_en),
        .wr_loop       (wr_loop),
        .wr_const      (wr_const),
        .wr_period     (wr_period),
        .start         (start),
`ifdef APU_ENV_MUTE_EN
        .len_nz        (len_nz),
`endif
        .volume        (volume)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Model: apply the quarter-frame step with the config held before this edge, then the write.
    task automatic model_edge();
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                m_loop[i] = 0; m_cnst[i] = 0; m_per[i] = 0;
                m_div[i] = 0; m_dec[i] = 0; m_sf[i] = 0;
            end else if (clk_en) begin
                if (quarter_frame) begin
                    if (m_sf[i] != 0 || start[i]) begin
                        m_dec[i] = DMAX; m_div[i] = m_per[i]; m_sf[i] = 0;
                    end else if (m_div[i] == 0) begin
                        m_div[i] = m_per[i];
                        if (m_dec[i] > 0) m_dec[i] = m_dec[i] - 1;
                        else m_dec[i] = m_loop[i] ? DMAX : 0;
                    end else begin
                        m_div[i] = m_div[i] - 1;
                    end
                end else if (start[i]) begin
                    m_sf[i] = 1;
                end
                if (wr_en[i]) begin
                    m_loop[i] = int'(wr_loop); m_cnst[i] = int'(wr_const); m_per[i] = int'(wr_period);
                end
            end
        end
    endtask

    function automatic int exp_vol(input int i);
        int v;
        v = (m_cnst[i] != 0) ? m_per[i] : m_dec[i];
`ifdef APU_ENV_MUTE_EN
        if (!len_nz[i]) v = 0;
`endif
        return v;
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < NUM_CH; i++)
            chk($sformatf("%s_ch%0d", tag, i), 32'(volume[i*VOL_W +: VOL_W]), 32'(exp_vol(i)));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        rst = 0; clk_en = 1; quarter_frame = 0; wr_en = '0; start = '0;
        wr_loop = 0; wr_const = 0; wr_period = '0;
    endtask

    task automatic cfg(input int ch, input logic lp, input logic cn, input int per);
        wr_en = '0; wr_en[ch] = 1'b1; wr_loop = lp; wr_const = cn; wr_period = PERIOD_W'(per);
        cyc("cfg");
        wr_en = '0;
    endtask

    task automatic run_ticks(input string tag, input int ticks, input int spacing);
        for (int t = 0; t < ticks * spacing; t++) begin
            quarter_frame = (t % spacing) == 0;
            cyc(tag);
        end
        quarter_frame = 0;
    endtask

    initial begin
        idle();
        len_nz = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            m_loop[i] = 0; m_cnst[i] = 0; m_per[i] = 0; m_div[i] = 0; m_dec[i] = 0; m_sf[i] = 0;
        end

        // reset, then quiet ticks keep volume at 0
        rst = 1;
        cyc("reset");
        for (int i = 0; i < NUM_CH; i++)
            chk("reset_zero", 32'(volume[i*VOL_W +: VOL_W]), 32'd0);
        rst = 0;
        run_ticks("quiet", 10, 4);

        // ch0 one-shot decay, period 2
        cfg(0, 1'b0, 1'b0, 2);
        start = 3'b001; cyc("start0"); start = '0;
        quarter_frame = 1; cyc("tick1"); quarter_frame = 0;
        chk("first_tick_15", 32'(volume[3:0]), 32'd15);
        run_ticks("decay0", 50, 4);
        chk("decay_floor", 32'(volume[3:0]), 32'd0);

        // ch1 looping, period 0
        cfg(1, 1'b1, 1'b0, 0);
        start = 3'b010; cyc("start1"); start = '0;
        run_ticks("loop1", 20, 2);

        // ch2 constant volume, then back to the running envelope
        cfg(2, 1'b0, 1'b1, 9);
        chk("const9", 32'(volume[11:8]), 32'd9);
        start = 3'b100; cyc("start2"); start = '0;
        run_ticks("const_run", 5, 3);
        cfg(2, 1'b0, 1'b0, 9);
        run_ticks("decay2", 6, 3);

        // start coincident with qf; cfg write coincident with qf
        cfg(0, 1'b0, 1'b0, 3);
        start = 3'b001; quarter_frame = 1; cyc("start_qf"); start = '0; quarter_frame = 0;
        chk("start_qf_15", 32'(volume[3:0]), 32'd15);
        run_ticks("after_start_qf", 4, 2);
        wr_en = 3'b001; wr_period = 4'd7; quarter_frame = 1; cyc("wr_qf");
        wr_en = '0; quarter_frame = 0;
        run_ticks("old_period", 12, 2);

        // clk_en low freezes everything
        for (int k = 0; k < 20; k++) begin
            clk_en = 0; quarter_frame = 1'($urandom); start = NUM_CH'($urandom);
            wr_en = NUM_CH'($urandom); wr_period = PERIOD_W'($urandom);
            wr_loop = 1'($urandom); wr_const = 1'($urandom);
            cyc("frozen");
        end
        idle();
`ifdef APU_ENV_MUTE_EN
        len_nz[0] = 0; cyc("mute");
        chk("mute_zero", 32'(volume[3:0]), 32'd0);
        len_nz[0] = 1; cyc("unmute");
`endif

        // random soak
        for (int k = 0; k < 3000; k++) begin
            rst           = ($urandom_range(0, 299) == 0);
            clk_en        = ($urandom_range(0, 7) != 0);
            quarter_frame = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < NUM_CH; i++) begin
                wr_en[i]  = ($urandom_range(0, 11) == 0);
                start[i]  = ($urandom_range(0, 15) == 0);
                len_nz[i] = ($urandom_range(0, 9) != 0);
            end
            wr_loop   = 1'($urandom);
            wr_const  = ($urandom_range(0, 3) == 0);
            wr_period = PERIOD_W'($urandom);
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
